// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out word serializer with valid/ready load (optional parity: PISO_SERIALIZER_PARITY_EN)
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             busy
);

`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FINAL_IDX = CW'(NBITS - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [WIDTH-1:0] shifted;
    logic             first_bit;
    logic             next_bit;
    logic             next_out;
    logic             accept;

    // A new word may enter when idle or exactly as the final bit is consumed,
    // which lets consecutive words stream without an idle bit between them.
    assign load_ready = !rst && ((state == S_IDLE) ||
                                 ((state == S_SHIFT) && last && shift_en));
    assign accept     = load_valid && load_ready;
    assign busy       = sout_valid;

    assign cnt_nxt   = cnt + 1'b1;
    assign first_bit = MSB_FIRST ? din[WIDTH-1] : din[0];
    assign shifted   = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
    assign next_bit  = MSB_FIRST ? shreg[WIDTH-2] : shreg[1];

`ifdef PISO_SERIALIZER_PARITY_EN
    logic parity_q;

    // Even parity of the captured word, presented after the last data bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            parity_q <= 1'b0;
        else if (accept)
            parity_q <= ^din;
    end

    assign next_out = (cnt_nxt == CW'(WIDTH)) ? parity_q : next_bit;
`else
    assign next_out = next_bit;
`endif

    // Word capture, bit advance and end-of-word handling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            shreg      <= '0;
            cnt        <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            last       <= 1'b0;
        end else if (accept) begin
            state      <= S_SHIFT;
            shreg      <= din;
            cnt        <= '0;
            sout       <= first_bit;
            sout_valid <= 1'b1;
            last       <= 1'b0;
        end else if ((state == S_SHIFT) && shift_en) begin
            if (last) begin
                state      <= S_IDLE;
                cnt        <= '0;
                sout       <= 1'b0;
                sout_valid <= 1'b0;
                last       <= 1'b0;
            end else begin
                shreg <= shifted;
                cnt   <= cnt_nxt;
                sout  <= next_out;
                last  <= (cnt_nxt == FINAL_IDX);
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for piso_serializer, MSB-first and LSB-first instances
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_valid = 1'b0;
    logic [W-1:0] din = '0;
    logic         shift_en = 1'b0;

    logic ready_m, sout_m, sv_m, last_m, busy_m;
    logic ready_l, sout_l, sv_l, last_l, busy_l;

    int total = 0;
    int bad   = 0;

    // each entry is {expected bit, expected last}
    logic [1:0] qm[$];
    logic [1:0] ql[$];

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ready_m),
        .din(din), .shift_en(shift_en), .sout(sout_m), .sout_valid(sv_m),
        .last(last_m), .busy(busy_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ready_l),
        .din(din), .shift_en(shift_en), .sout(sout_l), .sout_valid(sv_l),
        .last(last_l), .busy(busy_l)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a word becomes a list of NB bits in transmission order.
    task automatic push_word(input logic [W-1:0] w);
        int wi;
        wi = int'(w);
        for (int i = 0; i < W; i++) begin
            qm.push_back({1'((wi >> (W - 1 - i)) & 1), 1'(i == NB - 1)});
            ql.push_back({1'((wi >> i) & 1), 1'(i == NB - 1)});
        end
`ifdef PISO_SERIALIZER_PARITY_EN
        qm.push_back({^w, 1'b1});
        ql.push_back({^w, 1'b1});
`endif
    endtask

    // Monitor: compare presented bit, handshake readiness and consume on shift_en.
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy_m", 32'(busy_m), 32'(sv_m));
            chk("busy_l", 32'(busy_l), 32'(sv_l));
            chk("valid_m", 32'(sv_m), 32'(qm.size() != 0));
            chk("valid_l", 32'(sv_l), 32'(ql.size() != 0));
            chk("ready_m", 32'(ready_m), 32'((qm.size() == 0) || (qm.size() == 1 && shift_en)));
            chk("ready_l", 32'(ready_l), 32'((ql.size() == 0) || (ql.size() == 1 && shift_en)));
            if (qm.size() != 0) begin
                chk("sout_m", 32'(sout_m), 32'(qm[0][1]));
                chk("last_m", 32'(last_m), 32'(qm[0][0]));
            end
            if (ql.size() != 0) begin
                chk("sout_l", 32'(sout_l), 32'(ql[0][1]));
                chk("last_l", 32'(last_l), 32'(ql[0][0]));
            end
            if (shift_en && qm.size() != 0) void'(qm.pop_front());
            if (shift_en && ql.size() != 0) void'(ql.pop_front());
        end
    end

    // One clock of stimulus; the model queue being empty after the monitor's
    // pop means the serializer takes a word on the coming edge.
    task automatic cycle(input logic lv, input logic [W-1:0] w, input logic se, output bit took);
        @(posedge clk);
        #1;
        load_valid = lv;
        din        = w;
        shift_en   = se;
        @(negedge clk);
        #1;
        took = lv && !rst && (qm.size() == 0);
        if (took) push_word(w);
    endtask

    // se_mode: 0 always, 1 every third cycle, 2 random; lv_rand: random offer gaps.
    task automatic run_words(input logic [W-1:0] words[$], input int se_mode, input bit lv_rand);
        int idx = 0;
        int cyc = 0;
        bit took;
        logic lv, se;
        logic [W-1:0] w;
        while ((idx < words.size() || qm.size() != 0) && cyc < 3000) begin
            w  = (idx < words.size()) ? words[idx] : '0;
            lv = (idx < words.size()) && (lv_rand ? 1'($urandom_range(0, 1)) : 1'b1);
            case (se_mode)
                0:       se = 1'b1;
                1:       se = 1'((cyc % 3) == 2);
                default: se = 1'($urandom_range(0, 1));
            endcase
            cycle(lv, w, se, took);
            if (took) idx++;
            cyc++;
        end
        chk("drain_timeout", 32'(cyc < 3000), 32'd1);
        cycle(1'b0, '0, 1'b1, took);
        cycle(1'b0, '0, 1'b1, took);
    endtask

    initial begin
        logic [W-1:0] wl[$];
        bit took;

        #1;
        chk("rst_sout", 32'(sout_m), 32'd0);
        chk("rst_valid", 32'(sv_m), 32'd0);
        chk("rst_last", 32'(last_m), 32'd0);
        chk("rst_busy", 32'(busy_m), 32'd0);
        chk("rst_ready", 32'(ready_m), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(ready_m), 32'd1);

        wl = '{8'hA5};           run_words(wl, 0, 1'b0);
        wl = '{8'h01};           run_words(wl, 0, 1'b0);
        wl = '{8'hF0};           run_words(wl, 1, 1'b0);
        wl = '{8'hC3, 8'h3C};    run_words(wl, 0, 1'b0);
        wl = '{8'h07, 8'hA5};    run_words(wl, 0, 1'b0);

        wl.delete();
        for (int i = 0; i < 40; i++) wl.push_back(W'($urandom));
        run_words(wl, 2, 1'b1);
        wl.delete();
        for (int i = 0; i < 20; i++) wl.push_back(W'($urandom));
        run_words(wl, 0, 1'b0);

        // Reset in the middle of a word.
        cycle(1'b1, 8'hA5, 1'b1, took);
        chk("mid_accept", 32'(took), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, took);
        rst = 1'b1;
        #1;
        qm.delete();
        ql.delete();
        chk("mid_rst_sout", 32'(sout_m), 32'd0);
        chk("mid_rst_valid", 32'(sv_m), 32'd0);
        chk("mid_rst_last", 32'(last_m), 32'd0);
        chk("mid_rst_busy", 32'(busy_m), 32'd0);
        chk("mid_rst_ready", 32'(ready_m), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("ready_after_mid_rst", 32'(ready_m), 32'd1);
        for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1, took);

        wl = '{8'h5A};           run_words(wl, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out serializer with a valid/ready load handshake, selectable bit order, bit-rate enable and back-to-back word streaming. It converts WIDTH-bit words into a continuous serial bit stream with per-bit valid and a last-bit marker. It sits between a parallel word source (register file or FIFO) and a serial line driver, and supersedes the fixed 4-bit shift register.

## Interface
- WIDTH, 8, data word width; legal range is WIDTH >= 2.
- MSB_FIRST, 1, bit order: 1 sends din[WIDTH-1] first; 0 sends din[0] first.

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_valid  input  1  din holds a word to serialize.
- load_ready  output  1  serializer can accept a word this cycle (combinational).
- din  input  WIDTH  parallel word; sampled only on handshake.
- shift_en  input  1  bit-rate enable; the presented bit is consumed on an edge where this is 1.
- sout  output  1  current serial bit (registered).
- sout_valid  output  1  sout carries a valid bit (registered).
- last  output  1  the presented bit is the final bit of the word (registered).
- busy  output  1  a word is in flight; equals sout_valid.

## Operation
- Reset is asynchronous and active-high, as decided for this block.
- While rst = 1:
  - The state is IDLE; the shift register and the bit counter are 0.
  - sout, sout_valid, last and busy are 0.
  - load_ready is forced to 0.
- Two states: IDLE and SHIFT.
- Handshake: a word is accepted on an edge where load_valid && load_ready.
- load_ready = !rst && (IDLE || (SHIFT && last && shift_en)). This allows back-to-back words with no idle bit.
- On accept:
  - din is captured into the shift register and the bit counter clears to 0.
  - The state becomes SHIFT.
  - sout takes the first bit, selected by MSB_FIRST.
- In SHIFT, on an edge with shift_en = 1:
  - If the counter is below the final index, the register shifts toward the output end, the counter increments, and sout takes the next bit.
  - If last = 1, the word is complete. The block accepts a new word if one is offered; otherwise it returns to IDLE and sout, sout_valid and last go to 0.
- In SHIFT with shift_en = 0, every output holds its value.
- The counter is $clog2(WIDTH+1) bits wide. last is registered and asserts when the counter reaches the final index.
- din and load_valid are ignored when no handshake occurs.
- Reset mid-word: the partial word is discarded and nothing is resumed after reset deasserts.

## Timing
- A word accepted at edge N presents its first bit (sout_valid = 1) from edge N to N+1.
- Each bit is held until the first edge with shift_en = 1.
- A word occupies exactly WIDTH shift_en-qualified edges, or WIDTH+1 with the parity option.
- With shift_en tied to 1, a word takes WIDTH consecutive cycles, and continuous load_valid gives a 100% bit rate with no gaps.
- Next-word handshake: on the last-bit edge with shift_en = 1, the first bit of the new word appears on the very next cycle.

## Configuration
- PISO_SERIALIZER_PARITY_EN defined:
  - After the data bits, one even-parity bit (XOR of all captured din bits) is presented as an extra bit.
  - last asserts on the parity bit instead of the final data bit.
  - The word length becomes WIDTH+1 shift_en edges, and the load_ready rule applies to the parity bit.
- Not defined: there is no parity bit and the word length is WIDTH.

## Test plan
- Reset: assert rst mid-word (WIDTH=8, bit 3 presented) -> sout, sout_valid, last and busy drop to 0 without waiting for a clock and load_ready = 0. After release -> load_ready = 1 and the old word never reappears.
- MSB_FIRST=1, din=8'hA5, shift_en=1 -> sout = 1,0,1,0,0,1,0,1 on cycles N+1..N+8; last only on N+8; sout_valid=0 on N+9.
- MSB_FIRST=0, din=8'h01, shift_en=1 -> sout = 1,0,0,0,0,0,0,0; last on the 8th bit.
- shift_en pulsing once every 3 cycles, din=8'hF0 -> each bit held 3 cycles; the word spans 24 cycles; bit order unchanged.
- Back-to-back: 8'hC3 then 8'h3C with load_valid held -> load_ready high only on the last bit of 8'hC3; 16 contiguous valid bits with no gap.
- PARITY_EN: 8'hA5 -> 9th bit 0 with last on it; 8'h07 -> 9th bit 1.
